// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, colour constants and symbol-width helper for the code lock.
package lock_pkg;
  typedef enum logic [2:0] {LOCKED, ENTRY, UNLOCKED, PROG, LOCKOUT} state_t;
  localparam logic [2:0] RGB_LOCKED = 3'b100;
  localparam logic [2:0] RGB_ENTRY = 3'b001;
  localparam logic [2:0] RGB_UNLOCKED = 3'b010;
  localparam logic [2:0] RGB_PROG = 3'b011;
  function automatic int sym_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and turn a raw button into a one-cycle press pulse.
module btn_conditioner #(
  parameter int clk_freq = 50_000_000,
  parameter int stable_time = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int DB = clk_freq / 1000 * stable_time;
  localparam int CW = DB > 1 ? $clog2(DB) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);
  logic sync, stable, stable_q;
  logic [CW-1:0] cnt;
  // stable only follows sync after it has differed for DB consecutive cycles
  always_ff @(posedge clk)
    if (rst) begin
      sync <= 1'b0;
      stable <= 1'b0;
      stable_q <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= btn;
      cnt <= (sync != stable && cnt != DB_LAST) ? cnt + 1'b1 : '0;
      if (sync != stable && cnt == DB_LAST) stable <= sync;
      stable_q <= stable;
      pulse <= stable & ~stable_q;
    end
endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: programmable combination lock with lockout, inactivity timeout and status outputs.
module code_lock_ctrl import lock_pkg::*; #(
  parameter int clk_freq = 50_000_000,
  parameter int stable_time = 10,
  parameter int n_btn = 4,
  parameter int code_len = 4,
  parameter logic [code_len*sym_width(n_btn)-1:0] default_code = '0,
  parameter int max_fail = 3,
  parameter int lockout_cycles = 500_000_000,
  parameter int timeout_cycles = 250_000_000,
  parameter int flash_speed = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [n_btn-1:0]    btn,
  input  logic                prog_en,
  output logic [code_len-1:0] led,
  output logic [2:0]          rgb,
  output logic                unlocked,
  output logic                locked_out
);
  localparam int SW = sym_width(n_btn);
  localparam int CL = code_len * SW;
  localparam int NW = $clog2(code_len + 1);
  localparam int FW = $clog2(max_fail + 1);
  localparam int TMAX = lockout_cycles > timeout_cycles ? lockout_cycles : timeout_cycles;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [NW-1:0] LAST = NW'(code_len - 1);
  logic [n_btn-1:0] pulse;
  logic [SW-1:0] sym;
  logic press, valid, done, bad, bad_n;
  state_t state, state_n;
  logic [CL-1:0] code, code_n, entry, entry_n;
  logic [NW-1:0] cnt, cnt_n, pos;
  logic [FW-1:0] fail, fail_n;
  logic [TW-1:0] timer, timer_n;
  logic [flash_speed:0] flash, flash_n;
  logic [code_len-1:0] therm, led_n;
  logic [2:0] rgb_n;
  for (genvar i = 0; i < n_btn; i++) begin : g_cond
    btn_conditioner #(.clk_freq(clk_freq), .stable_time(stable_time)) u_cond (
      .clk(clk), .rst(rst), .btn(btn[i]), .pulse(pulse[i])
    );
  end
  always_comb begin
    sym = '0;
    for (int i = 0; i < n_btn; i++) if (pulse[i]) sym = SW'(i);
  end
  assign press = |pulse;
  assign valid = $onehot(pulse);
  assign pos = (state == ENTRY || state == PROG) ? cnt : '0;
  assign done = pos == LAST;
  always_comb begin
    state_n = state;
    code_n = code;
    entry_n = entry;
    bad_n = bad;
    cnt_n = cnt;
    fail_n = fail;
    timer_n = timer == '0 ? '0 : timer - 1'b1;
    case (state)
      LOCKED, ENTRY:
        if (press) begin
          entry_n[pos*SW +: SW] = sym;
          bad_n = (state == ENTRY && bad) || !valid;
          cnt_n = pos + 1'b1;
          timer_n = TW'(timeout_cycles);
          state_n = ENTRY;
          if (done) begin
            cnt_n = '0;
            if (!bad_n && entry_n == code) begin
              state_n = UNLOCKED;
              fail_n = '0;
            end else if (fail == FW'(max_fail - 1)) begin
              state_n = LOCKOUT;
              timer_n = TW'(lockout_cycles);
              fail_n = '0;
            end else begin
              state_n = LOCKED;
              fail_n = fail + 1'b1;
            end
          end
        end else if (state == ENTRY && timer <= TW'(1)) begin
          state_n = LOCKED;
          cnt_n = '0;
        end
      UNLOCKED, PROG:
        if (press) begin
          timer_n = TW'(timeout_cycles);
          if (valid && (state == PROG || prog_en)) begin
            entry_n[pos*SW +: SW] = sym;
            cnt_n = pos + 1'b1;
            state_n = PROG;
            if (done) begin
              code_n = entry_n;
              cnt_n = '0;
              state_n = LOCKED;
            end
          end else if (valid) state_n = LOCKED;
        end else if (state == PROG && timer <= TW'(1)) begin
          state_n = UNLOCKED;
          cnt_n = '0;
        end
      default:
        if (timer <= TW'(1)) begin
          state_n = LOCKED;
          timer_n = '0;
        end
    endcase
  end
  // outputs are registered from next-state values so they change with the state itself
  always_comb begin
    therm = '0;
    for (int i = 0; i < code_len; i++) therm[i] = NW'(i) < cnt_n;
  end
  assign flash_n = flash + 1'b1;
  assign led_n = state_n == UNLOCKED ? '1 : (state_n == ENTRY || state_n == PROG) ? therm : '0;
  assign rgb_n = state_n == LOCKED ? RGB_LOCKED :
                 state_n == ENTRY ? RGB_ENTRY :
                 state_n == UNLOCKED ? RGB_UNLOCKED :
                 state_n == PROG ? RGB_PROG : {flash_n[flash_speed], 2'b00};
  always_ff @(posedge clk)
    if (rst) begin
      state <= LOCKED;
      code <= default_code;
      entry <= '0;
      bad <= 1'b0;
      cnt <= '0;
      fail <= '0;
      timer <= '0;
      flash <= '0;
      led <= '0;
      rgb <= RGB_LOCKED;
      unlocked <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state <= state_n;
      code <= code_n;
      entry <= entry_n;
      bad <= bad_n;
      cnt <= cnt_n;
      fail <= fail_n;
      timer <= timer_n;
      flash <= flash_n;
      led <= led_n;
      rgb <= rgb_n;
      unlocked <= state_n == UNLOCKED || state_n == PROG;
      locked_out <= state_n == LOCKOUT;
    end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed and randomized press sequences checked against a press-level lock model.
module tb_code_lock_ctrl;
  localparam int M_LOCKED = 0, M_ENTRY = 1, M_UNLOCKED = 2, M_PROG = 3, M_LOCKOUT = 4;
  logic clk = 1'b0, rst = 1'b1, prog_en = 1'b0;
  logic [3:0] btn = '0;
  logic [3:0] led;
  logic [2:0] rgb;
  logic unlocked, locked_out;
  logic [8:0] obs;
  int checks = 0, errors = 0;
  int m_mode, m_fail;
  int m_code[4];
  int m_seq[$];
  int lo_run = 0, lo_len = 0;

  code_lock_ctrl #(
    .clk_freq(1000), .stable_time(2), .n_btn(4), .code_len(4),
    .default_code(8'b11_10_01_00), .max_fail(2), .lockout_cycles(50), .timeout_cycles(40)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .prog_en(prog_en),
    .led(led), .rgb(rgb), .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;
  assign obs = {led, rgb, unlocked, locked_out};

  always @(negedge clk)
    if (locked_out) lo_run++;
    else if (lo_run != 0) begin
      lo_len = lo_run;
      lo_run = 0;
    end

  function automatic logic [8:0] m_out();
    logic [3:0] l;
    logic [2:0] c;
    l = (m_mode == M_ENTRY || m_mode == M_PROG) ? 4'((1 << m_seq.size()) - 1) :
        m_mode == M_UNLOCKED ? 4'hf : 4'h0;
    c = m_mode == M_LOCKED ? 3'b100 : m_mode == M_ENTRY ? 3'b001 :
        m_mode == M_UNLOCKED ? 3'b010 : m_mode == M_PROG ? 3'b011 : 3'b000;
    return {l, c, m_mode == M_UNLOCKED || m_mode == M_PROG, m_mode == M_LOCKOUT};
  endfunction

  task automatic m_reset();
    m_mode = M_LOCKED;
    m_code = '{0, 1, 2, 3};
    m_seq.delete();
    m_fail = 0;
  endtask

  task automatic m_eval();
    bit ok = 1;
    for (int k = 0; k < 4; k++) if (m_seq[k] != m_code[k]) ok = 0;
    m_seq.delete();
    if (ok) begin
      m_mode = M_UNLOCKED;
      m_fail = 0;
    end else begin
      m_fail++;
      m_mode = m_fail == 2 ? M_LOCKOUT : M_LOCKED;
      if (m_fail == 2) m_fail = 0;
    end
  endtask

  task automatic m_press(input logic [3:0] mask);
    int s = $countones(mask) == 1 ? $clog2(mask) : -1;
    if (m_mode == M_LOCKED || m_mode == M_ENTRY) begin
      if (m_mode == M_LOCKED) m_seq.delete();
      m_seq.push_back(s);
      m_mode = M_ENTRY;
      if (m_seq.size() == 4) m_eval();
    end else if (m_mode == M_UNLOCKED && s >= 0) begin
      m_mode = prog_en ? M_PROG : M_LOCKED;
      m_seq.delete();
      if (prog_en) m_seq.push_back(s);
    end else if (m_mode == M_PROG && s >= 0) begin
      m_seq.push_back(s);
      if (m_seq.size() == 4) begin
        for (int k = 0; k < 4; k++) m_code[k] = m_seq[k];
        m_seq.delete();
        m_mode = M_LOCKED;
      end
    end
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk) btn = mask;
    repeat (5) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    m_press(mask);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = '0;
    prog_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL reset_led got %b exp 0000", led); end
    checks++; if (rgb !== 3'b100) begin errors++; $display("FAIL reset_rgb got %b exp 100", rgb); end
    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked got %b exp 0", unlocked); end
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked_out got %b exp 0", locked_out); end
  endtask

  task automatic test_unlock();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(4'(1 << i));
      checks++; if (obs !== m_out()) begin errors++; $display("FAIL unlock_%0d got %b exp %b", i, obs, m_out()); end
    end
    checks++; if ({led, rgb, unlocked} !== {4'hf, 3'b010, 1'b1}) begin errors++; $display("FAIL unlock_final got %b exp 11110101", {led, rgb, unlocked}); end
    press(4'b0001);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL relock got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_lockout();
    int n = 0;
    logic [3:0] seq[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) press(seq[i]);
      checks++; if (obs !== m_out()) begin errors++; $display("FAIL lockout_round%0d got %b exp %b", r, obs, m_out()); end
    end
    press(4'b0001);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL lockout_ignore got %b exp %b", obs, m_out()); end
    while (locked_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL lockout_end got %b exp 0", locked_out); end
    checks++; if (lo_len != 50) begin errors++; $display("FAIL lockout_len got %0d exp 50", lo_len); end
    m_mode = M_LOCKED;
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL lockout_exit got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_timeout();
    do_reset();
    press(4'b0001);
    press(4'b0010);
    repeat (25) @(negedge clk);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL timeout_early got %b exp %b", obs, m_out()); end
    repeat (25) @(negedge clk);
    m_mode = M_LOCKED;
    m_seq.delete();
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL timeout_fire got %b exp %b", obs, m_out()); end
    for (int i = 0; i < 4; i++) press(4'(1 << i));
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL timeout_unlock got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_prog();
    do_reset();
    for (int i = 0; i < 4; i++) press(4'(1 << i));
    prog_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press(4'b1000);
      checks++; if (obs !== m_out()) begin errors++; $display("FAIL prog_%0d got %b exp %b", i, obs, m_out()); end
    end
    prog_en = 1'b0;
    for (int i = 0; i < 4; i++) press(4'(1 << i));
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL prog_oldcode got %b exp %b", obs, m_out()); end
    for (int i = 0; i < 4; i++) press(4'b1000);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL prog_newcode got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_invalid();
    do_reset();
    press(4'b0011);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL invalid_seq got %b exp %b", obs, m_out()); end
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b0100);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL invalid_failcnt got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_bounce();
    do_reset();
    repeat (6) begin
      @(negedge clk) btn = 4'b0001;
      @(negedge clk) btn = 4'b0000;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL bounce got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 4; i++) press(4'(1 << i));
    prog_en = 1'b1;
    for (int i = 0; i < 4; i++) press(4'b1000);
    prog_en = 1'b0;
    press(4'b1000);
    press(4'b1000);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    m_reset();
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL rst_mid got %b exp %b", obs, m_out()); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) press(4'(1 << i));
    checks++; if (obs !== m_out()) begin errors++; $display("FAIL rst_default_code got %b exp %b", obs, m_out()); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int r;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      prog_en = $urandom_range(0, 2) == 0;
      r = $urandom_range(0, 9);
      if (r < 6 && (m_mode == M_LOCKED || m_mode == M_ENTRY))
        mask = 4'(1 << m_code[m_mode == M_LOCKED ? 0 : m_seq.size()]);
      else if (r == 9)
        mask = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
      else
        mask = 4'(1 << $urandom_range(0, 3));
      press(mask);
      checks++; if (obs !== m_out()) begin errors++; $display("FAIL random_%0d mask %b got %b exp %b", it, mask, obs, m_out()); end
      if (m_mode == M_LOCKOUT) begin
        repeat (55) @(negedge clk);
        m_mode = M_LOCKED;
        checks++; if (obs !== m_out()) begin errors++; $display("FAIL random_lockout_%0d got %b exp %b", it, obs, m_out()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_prog();
    test_invalid();
    test_bounce();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
